// File: rtl/topk_heap_sorter.sv
// topk_heap_sorter: streaming top-K selector using a one-level-per-cycle binary heap,
// drained worst-to-best over a ready/valid output.
module topk_heap_sorter #(
    parameter int DATA_WIDTH = 292,
    parameter int KEY_WIDTH  = 7,
    parameter int NLEVELS    = 3,
    parameter int MAX_MODE   = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  init,
    input  logic [NLEVELS-1:0]    k_cfg,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  in_last,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  out_last,
    output logic [NLEVELS-1:0]    count,
    output logic                  busy,
    output logic                  sort_end
);
    localparam int CAP = (1 << NLEVELS) - 1;
    localparam logic [NLEVELS-1:0] CAP_N = '1;

    typedef enum logic [2:0] {FILL, UP, DOWN, DRAIN, DSIFT, DONE} state_t;

    state_t state, nxt, fin;
    logic [DATA_WIDTH-1:0] mem [CAP];
    logic [NLEVELS-1:0] k_eff, idx, par;
    logic [NLEVELS:0] lc, rc, ch;
    logic last_seen, has_l, has_r, up_swap, dn_swap, deeper, accept_new, replace_root, drain_hs;

    function automatic logic better(input logic [KEY_WIDTH-1:0] a, input logic [KEY_WIDTH-1:0] b);
        return (MAX_MODE != 0) ? (a > b) : (a < b);
    endfunction

    assign par          = (idx - 1'b1) >> 1;
    assign lc           = {idx, 1'b1};
    assign rc           = lc + 1'b1;
    assign has_l        = lc < {1'b0, count};
    assign has_r        = rc < {1'b0, count};
    // the worse child is the one that must rise towards the root; ties keep the left child
    assign ch           = (has_r && better(mem[lc[NLEVELS-1:0]][KEY_WIDTH-1:0], mem[rc[NLEVELS-1:0]][KEY_WIDTH-1:0])) ? rc : lc;
    assign dn_swap      = has_l && better(mem[idx][KEY_WIDTH-1:0], mem[ch[NLEVELS-1:0]][KEY_WIDTH-1:0]);
    assign deeper       = {ch, 1'b1} < {2'b00, count};
    assign up_swap      = (idx != '0) && better(mem[par][KEY_WIDTH-1:0], mem[idx][KEY_WIDTH-1:0]);
    assign accept_new   = count < k_eff;
    assign replace_root = better(din[KEY_WIDTH-1:0], mem[0][KEY_WIDTH-1:0]);
    assign drain_hs     = (state == DRAIN) && (count != '0) && out_ready;
    assign fin          = last_seen ? DRAIN : FILL;

    assign in_ready  = state == FILL;
    assign out_valid = (state == DRAIN) && (count != '0);
    assign dout      = out_valid ? mem[0] : '0;
    assign out_last  = out_valid && (count == 1);
    assign busy      = state != FILL;
    assign sort_end  = state == DONE;

    always_comb begin
        nxt = state;
        case (state)
            FILL:        nxt = in_valid ? (accept_new ? UP : replace_root ? DOWN : in_last ? DRAIN : FILL)
                                        : (flush ? DRAIN : FILL);
            UP:          nxt = (up_swap && par != '0) ? UP : fin;
            DOWN:        nxt = (dn_swap && deeper) ? DOWN : fin;
            DSIFT:       nxt = (dn_swap && deeper) ? DSIFT : DRAIN;
            DRAIN:       nxt = (count == '0) ? DONE : out_ready ? ((count == 1) ? DONE : DSIFT) : DRAIN;
            DONE:        nxt = FILL;
            default:     nxt = FILL;
        endcase
        if (init) nxt = FILL;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= FILL;
            count     <= '0;
            k_eff     <= CAP_N;
            idx       <= '0;
            last_seen <= 1'b0;
        end else begin
            state <= nxt;
            if (init) begin
                count     <= '0;
                k_eff     <= (k_cfg == '0) ? CAP_N : k_cfg;
                last_seen <= 1'b0;
            end else begin
                case (state)
                    FILL: if (in_valid) begin
                        last_seen <= in_last;
                        idx       <= accept_new ? count : '0;
                        if (accept_new) count <= count + 1'b1;
                    end
                    UP:          if (up_swap) idx <= par;
                    DOWN, DSIFT: if (dn_swap) idx <= ch[NLEVELS-1:0];
                    DRAIN: if (drain_hs) begin
                        count <= count - 1'b1;
                        idx   <= '0;
                    end
                    DONE:        last_seen <= 1'b0;
                    default:     ;
                endcase
            end
        end
    end

    // heap storage needs no reset: only entries below count are ever observed
    always_ff @(posedge clk) begin
        if (!init) begin
            case (state)
                FILL: if (in_valid) begin
                    if (accept_new) mem[count] <= din;
                    else if (replace_root) mem[0] <= din;
                end
                UP: if (up_swap) begin
                    mem[idx] <= mem[par];
                    mem[par] <= mem[idx];
                end
                DOWN, DSIFT: if (dn_swap) begin
                    mem[idx]              <= mem[ch[NLEVELS-1:0]];
                    mem[ch[NLEVELS-1:0]]  <= mem[idx];
                end
                DRAIN: if (drain_hs) mem[0] <= mem[count - 1'b1];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_topk_heap_sorter.sv
// tb_topk_heap_sorter: directed top-K streams against a largest-K and a smallest-K instance.
module tb_topk_heap_sorter;
    localparam int DW = 292;

    logic clk = 1'b0, rstn = 1'b0, init = 1'b0, in_last = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic [2:0] k_cfg = '0;
    logic [DW-1:0] din = '0;
    logic in_ready_a, out_valid_a, out_last_a, busy_a, sort_end_a;
    logic in_ready_b, out_valid_b, out_last_b, busy_b, sort_end_b;
    logic [DW-1:0] dout_a, dout_b;
    logic [2:0] count_a, count_b;
    logic sel = 1'b0;
    logic rdy, ov, ol, se, bsy;
    logic [2:0] cnt;
    logic [DW-1:0] dv;
    logic [6:0] exp_k [8];
    int checks = 0, failures = 0;

    topk_heap_sorter #(.DATA_WIDTH(DW), .KEY_WIDTH(7), .NLEVELS(3), .MAX_MODE(1)) u_max (
        .clk(clk), .rstn(rstn), .init(init), .k_cfg(k_cfg), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .din(din), .in_last(in_last), .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
        .dout(dout_a), .out_last(out_last_a), .count(count_a), .busy(busy_a), .sort_end(sort_end_a));

    topk_heap_sorter #(.DATA_WIDTH(DW), .KEY_WIDTH(7), .NLEVELS(3), .MAX_MODE(0)) u_min (
        .clk(clk), .rstn(rstn), .init(init), .k_cfg(k_cfg), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .din(din), .in_last(in_last), .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
        .dout(dout_b), .out_last(out_last_b), .count(count_b), .busy(busy_b), .sort_end(sort_end_b));

    always #5 clk = ~clk;

    assign rdy = sel ? in_ready_b : in_ready_a;
    assign ov  = sel ? out_valid_b : out_valid_a;
    assign ol  = sel ? out_last_b : out_last_a;
    assign se  = sel ? sort_end_b : sort_end_a;
    assign bsy = sel ? busy_b : busy_a;
    assign cnt = sel ? count_b : count_a;
    assign dv  = sel ? dout_b : dout_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_init(input logic [2:0] k);
        init = 1'b1;
        k_cfg = k;
        @(posedge clk); #1;
        init = 1'b0;
    endtask

    task automatic send(input logic [6:0] key, input logic last);
        int i;
        din = '0;
        din[6:0] = key;
        din[DW-1 -: 8] = {1'b1, key};
        in_last = last;
        in_valid_a = !sel;
        in_valid_b = sel;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy) break;
        end
        if (i == 50) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain(input int n, input logic stall);
        int got = 0, cyc = 0;
        logic held = 1'b0, hl = 1'b0;
        logic [DW-1:0] hd = '0;
        while (got < n && cyc < 300) begin
            out_ready = stall ? (cyc % 3 == 0) : 1'b1;
            @(negedge clk);
            if (ov) begin
                if (held) begin
                    check("hold_dout", {31'd0, dv == hd}, 1);
                    check("hold_last", {31'd0, ol}, {31'd0, hl});
                end
                if (out_ready) begin
                    check("out_key", {25'd0, dv[6:0]}, {25'd0, exp_k[got]});
                    check("out_tag", {24'd0, dv[DW-1 -: 8]}, {24'd0, 1'b1, exp_k[got]});
                    check("out_last", {31'd0, ol}, {31'd0, got == n - 1});
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd = dv;
                    hl = ol;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_count", got, n);
        @(negedge clk);
        check("sort_end_pulse", {31'd0, se}, 1);
        check("count_after", {29'd0, cnt}, 0);
        check("no_extra_out", {31'd0, ov}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("sort_end_drop", {31'd0, se}, 0);
        check("idle_busy", {31'd0, bsy}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen, any_ov, i;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid_a}, 0);
        check("rst_count", {29'd0, count_a}, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_busy", {31'd0, busy_a}, 0);
        check("rst_sort_end", {31'd0, sort_end_a}, 0);
        check("rst_out_last", {31'd0, out_last_a}, 0);
        check("rst_dout", {31'd0, dout_a == '0}, 1);
        @(posedge clk); #1;

        // largest 4 of 5,9,1,7,3,8
        do_init(3'd4);
        sel = 1'b0;
        send(7'd5, 0); send(7'd9, 0); send(7'd1, 0); send(7'd7, 0); send(7'd3, 0); send(7'd8, 1);
        exp_k = '{7'd5, 7'd7, 7'd8, 7'd9, 7'd0, 7'd0, 7'd0, 7'd0};
        drain(4, 1'b0);

        // smallest 3 of 4,2,6,1,5; final beat discarded
        do_init(3'd3);
        sel = 1'b1;
        send(7'd4, 0); send(7'd2, 0); send(7'd6, 0); send(7'd1, 0); send(7'd5, 1);
        @(negedge clk);
        check("min_count_pre", {29'd0, cnt}, 3);
        check("min_busy_pre", {31'd0, bsy}, 1);
        @(posedge clk); #1;
        exp_k = '{7'd4, 7'd2, 7'd1, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        drain(3, 1'b0);

        // k_cfg=0 means full capacity; throttled drain
        do_init(3'd0);
        sel = 1'b0;
        for (i = 10; i >= 1; i--) send(7'(i), i == 1);
        exp_k = '{7'd4, 7'd5, 7'd6, 7'd7, 7'd8, 7'd9, 7'd10, 7'd0};
        drain(7, 1'b1);

        // flush with an empty heap
        seen = 0;
        any_ov = 0;
        flush = 1'b1;
        for (i = 0; i < 3; i++) begin
            @(negedge clk);
            if (se) seen++;
            if (ov) any_ov++;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        check("flush_sort_end", seen, 1);
        check("flush_no_out", any_ov, 0);

        // init while a drain sift is in progress
        do_init(3'd4);
        send(7'd5, 0); send(7'd9, 0); send(7'd1, 0); send(7'd7, 1);
        out_ready = 1'b1;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ov) break;
        end
        check("dsift_first_key", {25'd0, dv[6:0]}, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        init = 1'b1;
        @(negedge clk);
        check("dsift_busy", {31'd0, bsy}, 1);
        check("dsift_no_valid", {31'd0, ov}, 0);
        @(posedge clk); #1;
        init = 1'b0;
        @(negedge clk);
        check("init_out_valid", {31'd0, ov}, 0);
        check("init_count", {29'd0, cnt}, 0);
        check("init_in_ready", {31'd0, rdy}, 1);
        check("init_no_sort_end", {31'd0, se}, 0);
        @(posedge clk); #1;
        send(7'd2, 0); send(7'd6, 0); send(7'd4, 0); send(7'd8, 0); send(7'd3, 1);
        exp_k = '{7'd3, 7'd4, 7'd6, 7'd8, 7'd0, 7'd0, 7'd0, 7'd0};
        drain(4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
